// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: shared width defaults and requester ids for reg_arbiter
package reg_arb_pkg;
  localparam int DEF_DATA_W = 4;
  localparam int DEF_NUM_ENT = 4;
  localparam int DEF_CNT_W = 8;
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;
endpackage

// File: rtl/reg_bank.sv
// reg_bank: NUM_ENT x DATA_W storage; clk/rst, one write port (we/waddr/wdata), one combinational read port (raddr/rdata)
module reg_bank #(
  parameter int DATA_W = 4,
  parameter int NUM_ENT = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       we,
  input  logic [$clog2(NUM_ENT)-1:0] waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(NUM_ENT)-1:0] raddr,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [NUM_ENT];
  always_ff @(posedge clk)
    if (rst) for (int i = 0; i < NUM_ENT; i++) mem[i] <= '0;
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin two-requester access to reg_bank; req*/rsp* per requester, grant_cnt0/1 saturating counts, last_gnt pointer
module reg_arbiter
  import reg_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NUM_ENT = DEF_NUM_ENT,
  parameter int CNT_W = DEF_CNT_W
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic                       req0_we,
  input  logic [$clog2(NUM_ENT)-1:0] req0_addr,
  input  logic [DATA_W-1:0]          req0_wdata,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic                       req1_we,
  input  logic [$clog2(NUM_ENT)-1:0] req1_addr,
  input  logic [DATA_W-1:0]          req1_wdata,
  output logic                       rsp0_valid,
  output logic [DATA_W-1:0]          rsp0_rdata,
  output logic                       rsp1_valid,
  output logic [DATA_W-1:0]          rsp1_rdata,
  output logic [CNT_W-1:0]           grant_cnt0,
  output logic [CNT_W-1:0]           grant_cnt1,
  output logic                       last_gnt
);
  localparam int AW = $clog2(NUM_ENT);
  logic rsp0_q, rsp1_q, we, rd0, rd1;
  logic [AW-1:0] addr;
  logic [DATA_W-1:0] wdata, rdata;
  assign req0_ready = !rst && req0_valid && (!req1_valid || last_gnt == REQ1);
  assign req1_ready = !rst && req1_valid && (!req0_valid || last_gnt == REQ0);
  assign addr = req1_ready ? req1_addr : req0_addr;
  assign wdata = req1_ready ? req1_wdata : req0_wdata;
  assign we = (req0_ready && req0_we) || (req1_ready && req1_we);
  assign rd0 = req0_ready && !req0_we;
  assign rd1 = req1_ready && !req1_we;
  // masked by rst so a read granted just before reset never surfaces
  assign rsp0_valid = rsp0_q && !rst;
  assign rsp1_valid = rsp1_q && !rst;
  reg_bank #(.DATA_W(DATA_W), .NUM_ENT(NUM_ENT)) u_bank (
    .clk(clk), .rst(rst), .we(we), .waddr(addr), .wdata(wdata), .raddr(addr), .rdata(rdata)
  );
  always_ff @(posedge clk)
    if (rst) begin
      last_gnt <= REQ1;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      if (req0_ready || req1_ready) last_gnt <= req1_ready;
      if (req0_ready && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + CNT_W'(1);
      if (req1_ready && grant_cnt1 != '1) grant_cnt1 <= grant_cnt1 + CNT_W'(1);
      rsp0_q <= rd0;
      rsp1_q <= rd1;
      if (rd0) rsp0_rdata <= rdata;
      if (rd1) rsp1_rdata <= rdata;
    end
endmodule

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: random and directed stimulus checked against a behavioural model of reg_arbiter
module tb_reg_arbiter;
  logic clk = 0, rst = 0;
  logic v0 = 0, we0 = 0, v1 = 0, we1 = 0;
  logic [1:0] a0 = 0, a1 = 0;
  logic [3:0] d0 = 0, d1 = 0;
  logic r0, r1, rv0, rv1, lg;
  logic [3:0] rd0, rd1;
  logic [7:0] c0, c1;
  int total = 0, passed = 0;
  reg_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_we(we0), .req0_addr(a0), .req0_wdata(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_we(we1), .req1_addr(a1), .req1_wdata(d1),
    .rsp0_valid(rv0), .rsp0_rdata(rd0), .rsp1_valid(rv1), .rsp1_rdata(rd1),
    .grant_cnt0(c0), .grant_cnt1(c1), .last_gnt(lg)
  );
  always #5 clk = ~clk;
  int m_mem [4];
  int m_last, m_cnt [2], m_rspd [2];
  bit m_rspv [2];
  bit armed = 0;
  logic got_r0, got_r1;
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
  endtask
  function automatic int winner();
    if (rst) return -1;
    if (v0 && v1) return 1 - m_last;
    if (v0) return 0;
    if (v1) return 1;
    return -1;
  endfunction
  task automatic step(input bit r, input bit iv0, iwe0, input int ia0, id0, input bit iv1, iwe1, input int ia1, id1);
    int w;
    @(negedge clk);
    rst = r; v0 = iv0; we0 = iwe0; a0 = 2'(ia0); d0 = 4'(id0);
    v1 = iv1; we1 = iwe1; a1 = 2'(ia1); d1 = 4'(id1);
    #1;
    w = winner();
    got_r0 = r0; got_r1 = r1;
    if (armed) begin
      chk("ready0", int'(r0), int'(w == 0));
      chk("ready1", int'(r1), int'(w == 1));
      chk("rsp0_valid", int'(rv0), int'(m_rspv[0] && !r));
      chk("rsp1_valid", int'(rv1), int'(m_rspv[1] && !r));
      chk("rsp0_rdata", int'(rd0), m_rspd[0]);
      chk("rsp1_rdata", int'(rd1), m_rspd[1]);
      chk("grant_cnt0", int'(c0), m_cnt[0]);
      chk("grant_cnt1", int'(c1), m_cnt[1]);
      chk("last_gnt", int'(lg), m_last);
    end
    @(posedge clk);
    if (r) begin
      foreach (m_mem[i]) m_mem[i] = 0;
      m_last = 1; m_cnt = '{0, 0}; m_rspv = '{0, 0}; m_rspd = '{0, 0};
      armed = 1;
    end else begin
      m_rspv = '{0, 0};
      if (w >= 0) begin
        bit is_we = (w == 0) ? iwe0 : iwe1;
        int ad = (w == 0) ? ia0 : ia1;
        int dd = (w == 0) ? id0 : id1;
        m_last = w;
        if (m_cnt[w] < 255) m_cnt[w]++;
        if (is_we) m_mem[ad] = dd;
        else begin m_rspv[w] = 1; m_rspd[w] = m_mem[ad]; end
      end
    end
    #1;
  endtask
  task automatic idle(input bit r);
    step(r, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    int order [4];
    idle(1); idle(1);
    chk("reset last_gnt", int'(lg), 1);
    chk("reset cnt0", int'(c0), 0);
    chk("reset rsp0_valid", int'(rv0), 0);
    idle(0);
    step(0, 1, 0, 2, 0, 0, 0, 0, 0);
    chk("rd addr2 ready0", int'(got_r0), 1);
    chk("rd addr2 rsp0_valid", int'(rv0), 1);
    chk("rd addr2 rdata", int'(rd0), 0);
    step(0, 1, 1, 1, 4'hA, 0, 0, 0, 0);
    chk("wr A no rsp", int'(rv0), 0);
    step(0, 0, 0, 0, 0, 1, 0, 1, 0);
    chk("wr->rd rsp1_valid", int'(rv1), 1);
    chk("wr->rd rsp1_rdata", int'(rd1), 4'hA);
    idle(1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, i, 0, 1, 0, 3 - i, 0);
      order[i] = got_r0 ? 0 : 1;
    end
    foreach (order[i]) chk("contention order", order[i], i % 2);
    chk("contention cnt0", int'(c0), 2);
    chk("contention cnt1", int'(c1), 2);
    idle(1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, i, 0);
    step(0, 1, 0, 0, 0, 1, 0, 0, 0);
    chk("req0 wins after req1 run", int'(got_r0), 1);
    idle(1);
    for (int i = 0; i < 256; i++) step(0, 1, 1, i % 4, i % 16, 0, 0, 0, 0);
    chk("cnt0 at 255", int'(c0), 255);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0);
    chk("cnt0 saturated", int'(c0), 255);
    idle(1);
    step(0, 1, 1, 3, 5, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 3, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst after rd rsp1_valid", int'(rv1), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 0, 0, 1, 0, i, 0);
      chk("entry cleared rsp1_valid", int'(rv1), 1);
      chk("entry cleared", int'(rd1), 0);
    end
    for (int i = 0; i < 2000; i++)
      step($urandom_range(49) == 0, 1'($urandom), 1'($urandom), $urandom_range(3), $urandom_range(15),
           1'($urandom), 1'($urandom), $urandom_range(3), $urandom_range(15));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
